// File: rtl/sram_bist_pkg.sv
// Shared types for the SRAM March C- BIST controller: FSM states and the
// per-element march table (direction, op sequence, read/write data values).
package sram_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [2:0] elem_idx_t;

  localparam elem_idx_t FIRST_ELEM = 3'd0;
  localparam elem_idx_t LAST_ELEM  = 3'd5;

  typedef struct packed {
    logic down;       // 1 = sweep N-1..0, 0 = sweep 0..N-1
    logic has_read;
    logic has_write;
    logic rd_val;     // expected read data bit (replicated across the word)
    logic wr_val;     // write data bit (replicated across the word)
  } elem_cfg_t;

  // March C-: M0 up w0, M1 up r0w1, M2 up r1w0, M3 down r0w1, M4 down r1w0,
  // M5 down r0. Entries 6 and 7 are inert so any 3-bit index is in range.
  localparam elem_cfg_t MARCH_TABLE [8] = '{
    '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
    '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1},
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
    '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}
  };

  // An element whose first op at an address is a write has no read step.
  function automatic logic first_op_is_write(input elem_idx_t idx);
    return !MARCH_TABLE[idx].has_read;
  endfunction

endpackage

// File: rtl/sram_bist_ctrl_if.sv
// SRAM BIST-port bundle between the controller (master) and the memory (slave).
interface sram_bist_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  // Timing: a cycle with en & men & ren high reads addr; dout holds that word
  // in the following cycle. wen and ren are never high together.
  logic              en;
  logic              men;
  logic              wen;
  logic              ren;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] bm;
  logic [DATA_W-1:0] dout;

  modport master (
    output en, men, wen, ren, addr, din, bm,
    input  dout
  );

  modport slave (
    input  en, men, wen, ren, addr, din, bm,
    output dout
  );

endinterface

// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller: sequences the six march elements over the SRAM
// BIST port, compares each read one cycle later and latches the first failure.
module sram_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic              bist_en,
  output logic              bist_men,
  output logic              bist_wen,
  output logic              bist_ren,
  output logic [ADDR_W-1:0] bist_addr,
  output logic [DATA_W-1:0] bist_din,
  output logic [DATA_W-1:0] bist_bm,
  input  logic [DATA_W-1:0] bist_dout,
  output state_e            dbg_state
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  elem_idx_t         elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;   // 0 = read step, 1 = write step
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  elem_idx_t         fail_elem_q, fail_elem_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic              cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  elem_idx_t         cmp_elem_q, cmp_elem_d;

  logic              at_end;
  logic              mismatch;
  logic              run_d;
  elem_idx_t         elem_nxt;

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    elem_nxt    = elem_q + 3'd1;

    at_end = MARCH_TABLE[elem_q].down ? (addr_q == '0) : (addr_q == ADDR_MAX);

    // The op on the bus this cycle is a read; its data is checked next cycle.
    cmp_valid_d = ren_q;
    cmp_exp_d   = MARCH_TABLE[elem_q].rd_val;
    cmp_addr_d  = addr_q;
    cmp_elem_d  = elem_q;

    mismatch = cmp_valid_q && (bist_dout != {DATA_W{cmp_exp_q}});
    if (mismatch && pass_q) begin
      pass_d      = 1'b0;
      fail_addr_d = cmp_addr_q;
      fail_elem_d = cmp_elem_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          elem_d      = FIRST_ELEM;
          addr_d      = '0;
          phase_d     = first_op_is_write(FIRST_ELEM);
          pass_d      = 1'b1;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      RUN: begin
        if (MARCH_TABLE[elem_q].has_read && MARCH_TABLE[elem_q].has_write && !phase_q) begin
          phase_d = 1'b1;
        end else if (!at_end) begin
          addr_d  = MARCH_TABLE[elem_q].down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          phase_d = first_op_is_write(elem_q);
        end else if (elem_q == LAST_ELEM) begin
          state_d = FLUSH;
        end else begin
          elem_d  = elem_nxt;
          addr_d  = MARCH_TABLE[elem_nxt].down ? ADDR_MAX : '0;
          phase_d = first_op_is_write(elem_nxt);
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    run_d   = (state_d == RUN);
    busy_d  = run_d || (state_d == FLUSH);
    done_d  = (state_d == DONE);
    wen_d   = run_d && phase_d;
    ren_d   = run_d && !phase_d;
    baddr_d = run_d ? addr_d : '0;
    din_d   = (run_d && phase_d) ? {DATA_W{MARCH_TABLE[elem_d].wr_val}} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_q      <= FIRST_ELEM;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      baddr_q     <= '0;
      din_q       <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      baddr_q     <= baddr_d;
      din_q       <= din_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign bist_en   = busy_q;
  assign bist_men  = busy_q;
  assign bist_wen  = wen_q;
  assign bist_ren  = ren_q;
  assign bist_addr = baddr_q;
  assign bist_din  = din_q;
  assign bist_bm   = {DATA_W{busy_q}};
  assign dbg_state = state_q;

endmodule

// File: doc/sram_bist_ctrl.md
SRAM_BIST_CTRL -- requirements
Module: sram_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, SRAM address width; N = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM data width.
REQ-003 SHALL have port clk  input  1  clock; single clock domain, all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to run the test; honoured only in IDLE.
REQ-006 SHALL have port busy  output  1  test in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse at test end.
REQ-008 SHALL have port pass  output  1  result of last test (1 = no mismatch); valid from done until next accepted start.
REQ-009 SHALL have port fail_addr  output  ADDR_W  address of the first mismatch.
REQ-010 SHALL have port fail_elem  output  3  march element index (0..5) of the first mismatch.
REQ-011 SHALL have ports bist_en, bist_men, bist_wen, bist_ren  output  1 each  SRAM BIST-port controls.
REQ-012 SHALL have ports bist_addr (ADDR_W), bist_din (DATA_W), bist_bm (DATA_W)  output  SRAM BIST-port address, write data, bit mask.
REQ-013 SHALL have port bist_dout  input  DATA_W  SRAM read data, valid in the cycle after a read-enabled cycle.

Function
REQ-014 SHALL run March C-: M0 up w0; M1 up r0,w1; M2 up r1,w0; M3 down r0,w1; M4 down r1,w0; M5 down r0. Data 0 = all zeros, 1 = all ones.
REQ-015 SHALL use FSM states IDLE, RUN, FLUSH, DONE: IDLE->RUN on start; RUN->FLUSH after the final M5 read; FLUSH->DONE after one cycle; DONE->IDLE after one cycle.
REQ-016 SHALL issue the first M0 write in the cycle after start is sampled in IDLE.
REQ-017 SHALL spend one cycle per address in M0 and M5, and two cycles per address in M1-M4 (read cycle, then write cycle at the same address).
REQ-018 SHALL sweep "up" elements 0..N-1 and "down" elements N-1..0; the address counter SHALL wrap between elements without a skipped or repeated address.
REQ-019 SHALL hold busy high for exactly 10N+1 cycles (RUN plus FLUSH), i.e. 10241 cycles at ADDR_W=10.
REQ-020 SHALL assert done only in the DONE cycle.
REQ-021 SHALL sample bist_dout in the cycle after each read and compare it against the expected pattern; FLUSH exists only to compare the last M5 read.
REQ-022 SHALL record the first mismatch (fail_addr, fail_elem) and clear pass; later mismatches SHALL NOT overwrite it, and the test SHALL run to completion.
REQ-023 SHALL, on an accepted start, set pass=1 and fail_addr=0, fail_elem=0 before the first compare.
REQ-024 SHALL ignore start while busy or in DONE.
REQ-025 SHALL hold bist_en and bist_men high exactly while busy; bist_wen/bist_ren SHALL be high only in write/read cycles, never together; bist_bm SHALL be all ones while busy.
REQ-026 SHALL drive all outputs from registers.

Reset
REQ-027 SHALL, while rst is high, force state IDLE and busy=0, done=0, pass=0, fail_addr=0, fail_elem=0, all bist_* outputs 0.
REQ-028 SHALL abort a running test when rst is asserted, with no done pulse; rst has priority over start.

Structure
REQ-029 SHALL place the state enum and march-element encoding (element index, direction, op sequence, expected/write data) in package sram_bist_pkg.
REQ-030 SHALL be a single module; a one-cycle compare stage is inline, with no sub-module.

Verification (behavioural SRAM model with 1-cycle read latency, ADDR_W=10)
REQ-031 Fault-free model, start pulse -> busy high 10241 cycles, done pulse one cycle later, pass=1.
REQ-032 Bit 5 of address 0x155 stuck-at-1 -> pass=0, fail_addr=0x155, fail_elem=1.
REQ-033 Address 0x3FF bit 0 stuck-at-0 -> pass=0, fail_addr=0x3FF, fail_elem=2 (first "read 1").
REQ-034 Faults at 0x010 (stuck-1) and 0x020 (stuck-1) -> fail_addr=0x010, fail_elem=1; done still occurs after the full 10241 busy cycles.
REQ-035 start repeated mid-test, then rst at cycle 5000 -> extra start ignored; after reset all outputs 0, no done pulse; a new start completes normally.
REQ-036 Protocol monitor on every cycle -> bist_wen and bist_ren never both high; M3-M5 addresses descend from 0x3FF to 0x000; bist_en equals busy.
